// File: rtl/d_cache_write_buffer_pkg.sv
// Shared widths, AXI ID and FSM state types for the d_cache write-back buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package d_cache_write_buffer_pkg;
  localparam int ADDR_W = `ADDR_WIDTH;
  localparam int DATA_W = `DATA_WIDTH;

  // Every burst this block issues to memory carries ID 0.
  localparam logic [3:0] WB_AXI_ID = 4'd0;

  typedef enum logic [1:0] {F_IDLE, F_DATA, F_RESP} fill_state_t;
  typedef enum logic [1:0] {D_IDLE, D_ADDR, D_DATA, D_RESP} drain_state_t;
endpackage

// File: rtl/d_cache_write_buffer_if.sv
// One AXI port (AW, W, B, AR) as seen between the cache, this buffer and memory.
// Latency: n/a (wires only).
// Backpressure: plain valid/ready on every channel.
interface d_cache_write_buffer_if;
  import d_cache_write_buffer_pkg::*;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [3:0]        awid;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic              wlast;
  logic [3:0]        wid;
  logic              bvalid;
  logic              bready;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [3:0]        arid;

  modport master (
    output awvalid, awaddr, awlen, awid, wvalid, wdata, wlast, wid, bready,
           arvalid, araddr, arlen, arid,
    input  awready, wready, bvalid, arready
  );

  modport slave (
    input  awvalid, awaddr, awlen, awid, wvalid, wdata, wlast, wid, bready,
           arvalid, araddr, arlen, arid,
    output awready, wready, bvalid, arready
  );
endinterface

// File: rtl/d_cache_write_buffer_wb_line_store.sv
// Word storage for all buffered lines, indexed by {entry, beat}.
// Latency: write lands on the next edge; read is combinational.
// Backpressure: none, the FSMs in the parent decide when to write and read.
module d_cache_write_buffer_wb_line_store
  import d_cache_write_buffer_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [1 << IDX_W];

  // Single write port, fed by the fill FSM.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/d_cache_write_buffer.sv
// Posted write-back buffer: captures cache flush bursts, drains them to memory in order, holds hazarding reads.
// Latency: cache B one cycle after the last W beat; reads with no hazard pass through combinationally.
// Backpressure: c_awready low when all entries are full; AR held while its line is buffered; memory stalls drain only.
module d_cache_write_buffer
  import d_cache_write_buffer_pkg::*;
#(
  parameter int BLOCK_OFFSET_WIDTH = 2,
  parameter int DEPTH              = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  d_cache_write_buffer_if.slave   c_if,
  d_cache_write_buffer_if.master  m_if
);
  localparam int LINE_SIZE = 1 << BLOCK_OFFSET_WIDTH;
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W     = $clog2(DEPTH + 1);
  localparam int LA_LSB    = BLOCK_OFFSET_WIDTH + 2;
  localparam int LA_W      = ADDR_W - LA_LSB;
  localparam int IDX_W     = PTR_W + BLOCK_OFFSET_WIDTH;
  localparam logic [BLOCK_OFFSET_WIDTH-1:0] LAST_BEAT = BLOCK_OFFSET_WIDTH'(LINE_SIZE - 1);

  fill_state_t                   fill_state_q, fill_state_d;
  drain_state_t                  drain_state_q, drain_state_d;
  logic [BLOCK_OFFSET_WIDTH-1:0] fbeat_q, fbeat_d, dbeat_q, dbeat_d;
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic [DEPTH-1:0]              valid_q, valid_d;
  logic [LA_W-1:0]               line_addr_q [DEPTH];
  logic [LA_W-1:0]               line_addr_d [DEPTH];
  logic                          active_q, active_d;
  logic                          fill_done, drain_done, st_we, aw_ok, ar_hit;
  logic [LA_W-1:0]               ar_line;
  logic [DATA_W-1:0]             rd_word;
  logic                          unused_sigs;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  d_cache_write_buffer_wb_line_store #(.IDX_W(IDX_W)) u_store (
    .clk   (clk),
    .we    (st_we),
    .waddr ({wr_ptr_q, fbeat_q}),
    .wdata (c_if.wdata),
    .raddr ({rd_ptr_q, dbeat_q}),
    .rdata (rd_word)
  );

  // Fill FSM: accept one flush burst from the cache into entry[wr_ptr], then answer B.
  always_comb begin
    fill_state_d = fill_state_q;
    fbeat_d      = fbeat_q;
    wr_ptr_d     = wr_ptr_q;
    fill_done    = 1'b0;
    st_we        = 1'b0;
    aw_ok        = 1'b0;
    c_if.awready = 1'b0;
    c_if.wready  = 1'b0;
    c_if.bvalid  = 1'b0;
    for (int i = 0; i < DEPTH; i++) line_addr_d[i] = line_addr_q[i];
    case (fill_state_q)
      F_IDLE: begin
        // Registered count only: an entry freed this cycle is usable next cycle.
        aw_ok        = active_q && (count_q < CNT_W'(DEPTH));
        c_if.awready = aw_ok;
        if (c_if.awvalid && aw_ok) begin
          line_addr_d[wr_ptr_q] = c_if.awaddr[ADDR_W-1:LA_LSB];
          fbeat_d               = '0;
          fill_state_d          = F_DATA;
        end
      end
      F_DATA: begin
        c_if.wready = 1'b1;
        if (c_if.wvalid) begin
          st_we   = 1'b1;
          fbeat_d = fbeat_q + 1'b1;
          if (c_if.wlast || fbeat_q == LAST_BEAT) begin
            fill_done    = 1'b1;
            wr_ptr_d     = ptr_inc(wr_ptr_q);
            fill_state_d = F_RESP;
          end
        end
      end
      F_RESP: begin
        c_if.bvalid = 1'b1;
        if (c_if.bready) fill_state_d = F_IDLE;
      end
      default: fill_state_d = F_IDLE;
    endcase
  end

  // Drain FSM: send entry[rd_ptr] to memory as one AW, LINE_SIZE W beats, then wait for B.
  always_comb begin
    drain_state_d = drain_state_q;
    dbeat_d       = dbeat_q;
    rd_ptr_d      = rd_ptr_q;
    drain_done    = 1'b0;
    m_if.awvalid  = 1'b0;
    m_if.wvalid   = 1'b0;
    m_if.bready   = 1'b0;
    case (drain_state_q)
      D_IDLE: begin
        if (valid_q[rd_ptr_q]) begin
          dbeat_d       = '0;
          drain_state_d = D_ADDR;
        end
      end
      D_ADDR: begin
        m_if.awvalid = 1'b1;
        if (m_if.awready) drain_state_d = D_DATA;
      end
      D_DATA: begin
        m_if.wvalid = 1'b1;
        if (m_if.wready) begin
          if (dbeat_q == LAST_BEAT) drain_state_d = D_RESP;
          else                      dbeat_d       = dbeat_q + 1'b1;
        end
      end
      D_RESP: begin
        m_if.bready = 1'b1;
        if (m_if.bvalid) begin
          drain_done    = 1'b1;
          rd_ptr_d      = ptr_inc(rd_ptr_q);
          drain_state_d = D_IDLE;
        end
      end
      default: drain_state_d = D_IDLE;
    endcase
  end

  // Entry valid bits and occupancy; fill and drain never target the same entry.
  always_comb begin
    valid_d  = valid_q;
    active_d = 1'b1;
    if (drain_done) valid_d[rd_ptr_q] = 1'b0;
    if (fill_done)  valid_d[wr_ptr_q] = 1'b1;
    count_d = count_q + CNT_W'(fill_done) - CNT_W'(drain_done);
  end

  // Read hazard: a read to any buffered line waits until that line has reached memory.
  // The entry in F_RESP is already valid, so only the F_DATA entry needs its own term.
  always_comb begin
    ar_line = c_if.araddr[ADDR_W-1:LA_LSB];
    ar_hit  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && line_addr_q[i] == ar_line) ar_hit = 1'b1;
    end
    if (fill_state_q == F_DATA && line_addr_q[wr_ptr_q] == ar_line) ar_hit = 1'b1;
  end

  assign m_if.arvalid = active_q & c_if.arvalid & ~ar_hit;
  assign c_if.arready = active_q & m_if.arready & ~ar_hit;
  assign m_if.araddr  = c_if.araddr;
  assign m_if.arlen   = c_if.arlen;
  assign m_if.arid    = c_if.arid;

  assign m_if.awaddr = {line_addr_q[rd_ptr_q], {LA_LSB{1'b0}}};
  assign m_if.awlen  = 8'(LINE_SIZE);
  assign m_if.awid   = WB_AXI_ID;
  assign m_if.wid    = WB_AXI_ID;
  assign m_if.wdata  = rd_word;
  assign m_if.wlast  = (drain_state_q == D_DATA) && (dbeat_q == LAST_BEAT);

  // Burst length/ID from the cache are fixed by the line geometry and ignored here.
  assign unused_sigs = ^{c_if.awlen, c_if.awid, c_if.wid, c_if.awaddr[LA_LSB-1:0]};

  // State registers; reset abandons any burst in flight on either side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_state_q  <= F_IDLE;
      drain_state_q <= D_IDLE;
      fbeat_q       <= '0;
      dbeat_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      valid_q       <= '0;
      active_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) line_addr_q[i] <= '0;
    end else begin
      fill_state_q  <= fill_state_d;
      drain_state_q <= drain_state_d;
      fbeat_q       <= fbeat_d;
      dbeat_q       <= dbeat_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
      active_q      <= active_d;
      for (int i = 0; i < DEPTH; i++) line_addr_q[i] <= line_addr_d[i];
    end
  end
endmodule

// File: tb/tb_d_cache_write_buffer.sv
// Directed bench for d_cache_write_buffer with a memory-side responder and scoreboard.
// Latency: checks cache B one cycle after the last beat and read release one cycle after memory B.
// Backpressure: memory AW/W/B readiness is steered by knobs from the main sequence.
module tb_d_cache_write_buffer;
  import d_cache_write_buffer_pkg::*;

  logic clk;
  logic rst_n;

  d_cache_write_buffer_if c_if ();
  d_cache_write_buffer_if m_if ();

  d_cache_write_buffer #(.BLOCK_OFFSET_WIDTH(2), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .c_if  (c_if),
    .m_if  (m_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          errors = 0;
  int          checks = 0;
  int          n_flush = 0;
  int          mem_b_cnt = 0;
  int          b_pending = 0;
  int          w_beat = 0;
  int          acc_wait, acc_bdt, acc_bcnt, b_before;
  bit          mem_aw_en = 1'b1;
  bit          mem_b_en = 1'b1;
  bit          mem_w_toggle = 1'b0;
  bit          w_tog = 1'b0;
  bit          w_stalled = 1'b0;
  logic [31:0] w_prev = '0;
  time         last_b_time = 0;
  logic [31:0] q_aw [$];
  logic [31:0] q_w  [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: drives AW/W/B readiness at negedge, checks what the DUT sends.
  initial begin
    logic [31:0] exp;
    m_if.awready = 1'b0;
    m_if.wready  = 1'b0;
    m_if.bvalid  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        b_pending    = 0;
        w_beat       = 0;
        w_stalled    = 1'b0;
        m_if.awready = 1'b0;
        m_if.wready  = 1'b0;
        m_if.bvalid  = 1'b0;
      end else begin
        w_tog        = ~w_tog;
        m_if.awready = mem_aw_en;
        m_if.wready  = mem_w_toggle ? w_tog : 1'b1;
        m_if.bvalid  = mem_b_en && (b_pending > 0);
        #1;
        if (m_if.awvalid && m_if.awready) begin
          exp = (q_aw.size() > 0) ? q_aw.pop_front() : 'x;
          check("m_awaddr", m_if.awaddr, exp);
          check("m_awlen", 32'(m_if.awlen), 32'd4);
          check("m_awid", 32'(m_if.awid), 32'd0);
        end
        if (m_if.wvalid) begin
          if (w_stalled) check("m_wdata_stable", m_if.wdata, w_prev);
          if (m_if.wready) begin
            exp = (q_w.size() > 0) ? q_w.pop_front() : 'x;
            check("m_wdata", m_if.wdata, exp);
            check("m_wlast", 32'(m_if.wlast), 32'(w_beat == 3));
            if (w_beat == 3) begin
              w_beat = 0;
              b_pending++;
            end else begin
              w_beat++;
            end
            w_stalled = 1'b0;
          end else begin
            w_stalled = 1'b1;
          end
          w_prev = m_if.wdata;
        end else begin
          w_stalled = 1'b0;
        end
        if (m_if.bvalid && m_if.bready) begin
          b_pending--;
          mem_b_cnt++;
          last_b_time = $time;
        end
      end
    end
  end

  // Cache-side flush: AW then four beats base..base+3; expects B the cycle after the last beat.
  task automatic flush(input logic [31:0] addr, input logic [31:0] base);
    int n = 0;
    @(negedge clk);
    c_if.awvalid = 1'b1;
    c_if.awaddr  = addr;
    #1;
    while (!c_if.awready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    acc_wait = n;
    acc_bdt  = int'($time - last_b_time);
    acc_bcnt = mem_b_cnt;
    check("c_awready", 32'(c_if.awready), 32'd1);
    if (c_if.awready) begin
      n_flush++;
      q_aw.push_back(addr);
      for (int b = 0; b < 4; b++) q_w.push_back(base + 32'(b));
    end
    @(negedge clk);
    c_if.awvalid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      c_if.wvalid = 1'b1;
      c_if.wdata  = base + 32'(b);
      c_if.wlast  = (b == 3);
      #1;
      n = 0;
      while (!c_if.wready && n < 50) begin
        @(negedge clk);
        #1;
        n++;
      end
      @(negedge clk);
    end
    c_if.wvalid = 1'b0;
    c_if.wlast  = 1'b0;
    #1;
    check("c_bvalid_latency", 32'(c_if.bvalid), 32'd1);
  endtask

  task automatic wait_drained();
    int n = 0;
    while (mem_b_cnt != n_flush && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_done", mem_b_cnt, n_flush);
    check("sb_empty", q_aw.size() + q_w.size(), 0);
  endtask

  initial begin
    int n;
    rst_n        = 1'b0;
    c_if.awvalid = 1'b0;
    c_if.awaddr  = '0;
    c_if.awlen   = 8'd3;
    c_if.awid    = 4'd1;
    c_if.wvalid  = 1'b0;
    c_if.wdata   = '0;
    c_if.wlast   = 1'b0;
    c_if.wid     = 4'd1;
    c_if.bready  = 1'b1;
    c_if.arvalid = 1'b0;
    c_if.araddr  = '0;
    c_if.arlen   = 8'd3;
    c_if.arid    = 4'd2;
    m_if.arready = 1'b1;

    // Reset values
    #12;
    check("rst_c_awready", 32'(c_if.awready), 32'd0);
    check("rst_c_arready", 32'(c_if.arready), 32'd0);
    check("rst_c_bvalid", 32'(c_if.bvalid), 32'd0);
    check("rst_m_awvalid", 32'(m_if.awvalid), 32'd0);
    check("rst_m_wvalid", 32'(m_if.wvalid), 32'd0);
    check("rst_m_bready", 32'(m_if.bready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("idle_c_awready", 32'(c_if.awready), 32'd1);
    check("idle_count", 32'(dut.count_q), 32'd0);

    // Single flush, drained straight to memory
    flush(32'h0000_1200, 32'hA0);
    wait_drained();

    // Read hazard against a held line, unrelated read passes through
    mem_aw_en = 1'b0;
    flush(32'h0000_1200, 32'hB0);
    c_if.arvalid = 1'b1;
    c_if.araddr  = 32'h0000_1208;
    #1;
    check("haz_m_arvalid", 32'(m_if.arvalid), 32'd0);
    check("haz_c_arready", 32'(c_if.arready), 32'd0);
    c_if.araddr = 32'h0000_2000;
    #1;
    check("miss_m_arvalid", 32'(m_if.arvalid), 32'd1);
    check("miss_c_arready", 32'(c_if.arready), 32'd1);
    check("miss_m_araddr", m_if.araddr, 32'h0000_2000);
    c_if.araddr = 32'h0000_1208;
    mem_aw_en   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!m_if.arvalid && n < 300);
    check("haz_release", 32'(m_if.arvalid), 32'd1);
    check("haz_release_b_count", mem_b_cnt, n_flush);
    check("haz_release_after_b", int'($time - last_b_time), 10);
    c_if.arvalid = 1'b0;
    wait_drained();

    // Fill to full with memory AW blocked; third burst waits for the first B
    mem_aw_en = 1'b0;
    flush(32'h0000_3000, 32'hC0);
    flush(32'h0000_4000, 32'hD0);
    b_before = mem_b_cnt;
    fork
      flush(32'h0000_5000, 32'hE0);
      begin
        repeat (6) @(negedge clk);
        #2;
        mem_aw_en = 1'b1;
      end
    join
    check("full_stall", 32'(acc_wait >= 5), 32'd1);
    check("full_release_b_count", acc_bcnt, b_before + 1);
    check("full_release_after_b", acc_bdt, 10);
    wait_drained();

    // Memory W backpressure toggling every cycle
    mem_w_toggle = 1'b1;
    flush(32'h0000_6000, 32'h60);
    wait_drained();
    mem_w_toggle = 1'b0;

    // Simultaneous fill completion and drain B at count 1, rd_ptr wraps 1 -> 0
    flush(32'h0000_7000, 32'h70);
    wait_drained();
    mem_b_en = 1'b0;
    flush(32'h0000_8000, 32'h80);
    n = 0;
    while (b_pending == 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("sim_count_before", 32'(dut.count_q), 32'd1);
    check("sim_rd_ptr_before", 32'(dut.rd_ptr_q), 32'd1);
    fork
      flush(32'h0000_9000, 32'h90);
      begin
        repeat (4) @(negedge clk);
        #2;
        mem_b_en = 1'b1;
      end
    join
    check("sim_count_after", 32'(dut.count_q), 32'd1);
    check("sim_rd_ptr_after", 32'(dut.rd_ptr_q), 32'd0);
    check("sim_wr_ptr_after", 32'(dut.wr_ptr_q), 32'd1);
    wait_drained();

    // Reset in the middle of a drain burst
    mem_w_toggle = 1'b1;
    flush(32'h0000_A000, 32'h50);
    n = 0;
    while (w_beat != 2 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("mid_burst_reached", w_beat, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_m_wvalid", 32'(m_if.wvalid), 32'd0);
    check("arst_m_awvalid", 32'(m_if.awvalid), 32'd0);
    check("arst_c_awready", 32'(c_if.awready), 32'd0);
    check("arst_m_bready", 32'(m_if.bready), 32'd0);
    q_aw.delete();
    q_w.delete();
    mem_w_toggle = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("post_rst_count", 32'(dut.count_q), 32'd0);
    check("post_rst_m_awvalid", 32'(m_if.awvalid), 32'd0);
    check("post_rst_m_wvalid", 32'(m_if.wvalid), 32'd0);
    check("post_rst_c_awready", 32'(c_if.awready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/d_cache_write_buffer.md
Name: d_cache_write_buffer

Overview:
- Posted write-back buffer between the d_cache AXI write master and the memory-side AXI write slave.
- Accepts each dirty-line flush burst from the data cache at full rate and returns the write response as soon as the line is captured, so the cache can start its refill immediately.
- Drains buffered lines to memory in FIFO order.
- Gates the cache's read-address channel while the requested line sits in the buffer, so reads never overtake a pending write-back.

Parameters:
- BLOCK_OFFSET_WIDTH, 2, log2 words per line; must match d_cache. LINE_SIZE = 1 << BLOCK_OFFSET_WIDTH.
- DEPTH, 2, number of line entries (power of two, >= 1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- c_awvalid / c_awready  in / out  1 / 1  cache-side write address handshake
- c_awaddr  in  `ADDR_WIDTH  line-aligned flush address
- c_awlen, c_awid  in  8, 4  accepted; not used internally
- c_wvalid / c_wready  in / out  1 / 1  cache-side write data handshake
- c_wdata  in  `DATA_WIDTH  write data beat
- c_wlast  in  1  last beat of the burst
- c_bvalid / c_bready  out / in  1 / 1  cache-side write response handshake
- c_arvalid / c_arready  in / out  1 / 1  cache-side read address handshake
- c_araddr  in  `ADDR_WIDTH  read address
- c_arlen, c_arid  in  8, 4  read burst length and ID
- m_awvalid / m_awready  out / in  1 / 1  memory-side write address handshake
- m_awaddr  out  `ADDR_WIDTH  write address
- m_awlen, m_awid  out  8, 4  m_awlen = LINE_SIZE (codebase convention); m_awid = 0
- m_wvalid / m_wready  out / in  1 / 1  memory-side write data handshake
- m_wdata  out  `DATA_WIDTH  write data beat
- m_wlast  out  1  last beat of the burst
- m_wid  out  4  = 0
- m_bvalid / m_bready  in / out  1 / 1  memory-side write response handshake
- m_arvalid / m_arready  out / in  1 / 1  memory-side read address handshake
- m_araddr, m_arlen, m_arid  out  `ADDR_WIDTH, 8, 4  pass-through of c_araddr, c_arlen, c_arid

Behaviour:
- Reset (async, rst_n low):
  - all entries invalid, count = 0, both FSMs idle.
  - all *valid/*ready outputs 0; m_bready 0.
  - An in-flight burst on either side is abandoned; memory is reset together with this block.
- Storage: DEPTH entries, each a line address (tag+index = addr[`ADDR_WIDTH-1 : BLOCK_OFFSET_WIDTH+2]) plus LINE_SIZE words.
- Pointers: wr_ptr, rd_ptr (log2 DEPTH bits, wrap modulo DEPTH); count is 0..DEPTH.
- Fill FSM, states F_IDLE, F_DATA, F_RESP:
  - F_IDLE: c_awready = (count < DEPTH). On handshake, latch the line address into entry[wr_ptr], clear the beat counter, go to F_DATA.
  - F_DATA: c_wready = 1. Each beat writes word[beat] and increments the beat counter. On the beat with c_wlast (or beat == LINE_SIZE-1): mark the entry valid, increment wr_ptr, go to F_RESP.
  - F_RESP: c_bvalid = 1 until c_bready, then go to F_IDLE. Response latency is 1 cycle after the last W beat.
- Drain FSM, states D_IDLE, D_ADDR, D_DATA, D_RESP:
  - D_IDLE: if entry[rd_ptr] is valid, go to D_ADDR.
  - D_ADDR: m_awvalid = 1, m_awaddr = {line_addr, zeros}. On m_awready, go to D_DATA.
  - D_DATA: m_wvalid = 1, m_wdata = word[beat], m_wlast = (beat == LINE_SIZE-1). The beat counter advances on m_wready; the last handshake goes to D_RESP.
  - D_RESP: m_bready = 1. On m_bvalid, invalidate the entry, increment rd_ptr, go to D_IDLE.
- Count: +1 on fill completion, -1 on drain completion; simultaneous completion leaves it unchanged.
- Full: count == DEPTH holds c_awready = 0. A new fill may start the same cycle drain completion frees an entry only if count was already < DEPTH (registered count; no same-cycle bypass).
- Empty: the drain FSM stays in D_IDLE; all m_* valids are 0.
- Read hazard gate: hit = c_araddr line matches any valid entry, or the entry being filled (F_DATA/F_RESP).
  - m_arvalid = c_arvalid & ~hit.
  - c_arready = m_arready & ~hit.
  - Combinational, zero added latency when there is no hit.
  - While hit holds, the read stalls and is released automatically once the matching entry drains.
- The read data channel does not pass through this block.

Decomposition:
- mips_core_pkg: fill_state_t and drain_state_t enums; WB_AXI_ID constant (0).
- Widths come from `ADDR_WIDTH / `DATA_WIDTH in mips_core.svh.
- One natural sub-module: wb_line_store, the DEPTH x LINE_SIZE word array with a single write port and an asynchronous read port indexed by {rd_ptr, beat}.
- Address compare and the FSMs stay in the top module.

Test Plan:
- Single flush (LINE_SIZE=4): AW 0x0001200, W beats 0xA0..0xA3 -> c_bvalid the cycle after beat 3; memory later sees AW 0x0001200 with AWLEN 4 and the same 4 words in order, WLAST on the 4th beat.
- Fill to full with DEPTH=2 and m_awready held 0: two bursts accepted -> third burst sees c_awready = 0 until the first memory B returns, then it is accepted.
- Read hazard: flush line 0x0001200, then c_araddr 0x0001208 while the entry is valid -> m_arvalid = 0 and c_arready = 0 until m_bvalid for that line; the next cycle m_arvalid = 1. Read to 0x0002000 -> passes through the same cycle.
- Back-pressure: m_wready toggling 1,0,1,0 -> each word is sent exactly once and in order, and m_wdata is stable while m_wready is 0.
- Simultaneous events: fill completion and drain B in the same cycle at count = 1 -> count stays 1, and pointers advance correctly across wrap (rd_ptr 1 -> 0).
- Reset mid-burst: assert rst_n low during beat 2 of a drain -> all valids drop immediately (async); after release count = 0, no m_awvalid, and c_awready = 1.
